// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//   Iterative AES encryption control. The round function and the key expansion
//   are external. This block holds the state and round-key registers, counts
//   rounds, and performs the valid/ready handshakes on the input and output sides.
//
//   Parameter NROUNDS : rounds per block (10 for AES-128, at most 15)
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     in_valid/in_ready       input handshake for in_block (plaintext) and in_key
//     out_valid/out_ready     output handshake for out_block (ciphertext)
//     rnd_state_o, rnd_key_o  state and round-key registers, sent to the datapath
//     rnd_idx, rnd_last       current round (1..NROUNDS) and final-round flag;
//                             both are 0 outside RUN
//     rnd_state_i, rnd_key_i  next state and next round key from the datapath
//
//   Optional feature (macro AES_BLOCK_CNT_EN):
//     blk_cnt [15:0]          count of completed output handshakes; wraps to 0
module aes_round_sequencer #(
  parameter int unsigned NROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic [127:0] rnd_state_o,
  output logic [127:0] rnd_key_o,
  output logic [3:0]   rnd_idx,
  output logic         rnd_last,
  input  logic [127:0] rnd_state_i,
  input  logic [127:0] rnd_key_i
`ifdef AES_BLOCK_CNT_EN
  ,
  output logic [15:0]  blk_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } st_t;

  localparam logic [3:0] LAST_RND = 4'(NROUNDS);

  st_t          st;
  logic [127:0] state_q;
  logic [127:0] key_q;
  logic [3:0]   round_q;
  logic         last_q;
  logic         valid_q;
  logic         take;

  // An input handshake in DONE (with out_ready) reloads directly and skips IDLE.
  assign in_ready    = (st == IDLE) || ((st == DONE) && out_ready);
  assign take        = in_valid && in_ready;

  assign out_valid   = valid_q;
  assign out_block   = state_q;
  assign rnd_state_o = state_q;
  assign rnd_key_o   = key_q;
  assign rnd_idx     = round_q;
  assign rnd_last    = last_q;

  // round_q and last_q are cleared when RUN is left. As a result, rnd_idx and
  // rnd_last come straight from flops and are 0 outside RUN without gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (take) begin
      st      <= RUN;
      state_q <= in_block ^ in_key;
      key_q   <= in_key;
      round_q <= 4'd1;
      last_q  <= (LAST_RND == 4'd1);
      valid_q <= 1'b0;
    end else begin
      case (st)
        RUN: begin
          state_q <= rnd_state_i;
          key_q   <= rnd_key_i;
          if (last_q) begin
            st      <= DONE;
            round_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            round_q <= round_q + 4'd1;
            last_q  <= ((round_q + 4'd1) == LAST_RND);
          end
        end
        DONE: begin
          if (out_ready) begin
            st      <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

`ifdef AES_BLOCK_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
    end else if (valid_q && out_ready) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif

endmodule
